// File: rtl/aes_key_schedule_ctrl.sv
// Sequential AES-128 key-schedule controller: expands one round key per cycle
// through a single shared SubWord path into an 11-entry register file.
module aes_key_schedule_ctrl #(
   parameter int NUM_ROUNDS = 10,
   parameter int ADDR_W     = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [127:0]      key_in,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic              abort,
   input  logic [ADDR_W-1:0] rk_addr,
   output logic [127:0]      rk_out,
   output logic              sched_done,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

   // Forward S-box, row-major: byte x lives at bit offset (255-x)*8.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [7:0] RCON_TBL [11] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[{~x, 3'b000} +: 8];
   endfunction

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] rnd_q, rnd_d;
   logic [127:0]      rk_q [NUM_ROUNDS+1];
   logic [127:0]      rk_d [NUM_ROUNDS+1];
   logic [127:0]      rk_out_q, rk_out_d;

   logic [127:0]      prev_key, next_key;
   logic [31:0]       w0, w1, w2, w3, sub_word, t;
   logic [31:0]       n0, n1, n2, n3;
   logic [7:0]        rcon;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_idx;
   logic [127:0]      wr_data;

   // One expansion step: previous round key selected by rnd, single SubWord.
   always_comb begin
      prev_key = '0;
      rcon     = '0;
      for (int i = 0; i < NUM_ROUNDS; i++) begin
         if (rnd_q == ADDR_W'(i + 1)) begin
            prev_key = rk_q[i];
            rcon     = RCON_TBL[i + 1];
         end
      end
      w0       = prev_key[127:96];
      w1       = prev_key[95:64];
      w2       = prev_key[63:32];
      w3       = prev_key[31:0];
      sub_word = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      t        = sub_word ^ {rcon, 24'h0};
      n0       = w0 ^ t;
      n1       = n0 ^ w1;
      n2       = n1 ^ w2;
      n3       = n2 ^ w3;
      next_key = {n0, n1, n2, n3};
   end

   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      wr_en   = 1'b0;
      wr_idx  = '0;
      wr_data = '0;
      case (state_q)
         IDLE, DONE: begin
            if (key_valid) begin
               wr_en   = 1'b1;
               wr_data = key_in;
               rnd_d   = ADDR_W'(1);
               state_d = EXPAND;
            end
         end
         EXPAND: begin
            // Abort takes priority and suppresses this cycle's write.
            if (abort) begin
               rnd_d   = '0;
               state_d = IDLE;
            end else begin
               wr_en   = 1'b1;
               wr_idx  = rnd_q;
               wr_data = next_key;
               if (rnd_q == ADDR_W'(NUM_ROUNDS)) begin
                  rnd_d   = '0;
                  state_d = DONE;
               end else begin
                  rnd_d = rnd_q + ADDR_W'(1);
               end
            end
         end
         default: begin
            rnd_d   = '0;
            state_d = IDLE;
         end
      endcase

      for (int i = 0; i <= NUM_ROUNDS; i++) begin
         rk_d[i] = (wr_en && (wr_idx == ADDR_W'(i))) ? wr_data : rk_q[i];
      end

      // Out-of-range indices read as zero; reads see pre-write contents.
      rk_out_d = '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
         if (rk_addr == ADDR_W'(i)) begin
            rk_out_d = rk_q[i];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         rnd_q    <= '0;
         rk_out_q <= '0;
         for (int i = 0; i <= NUM_ROUNDS; i++) begin
            rk_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         rnd_q    <= rnd_d;
         rk_out_q <= rk_out_d;
         rk_q     <= rk_d;
      end
   end

   assign key_ready  = (state_q == IDLE) || (state_q == DONE);
   assign busy       = (state_q == EXPAND);
   assign sched_done = (state_q == DONE);
   assign rk_out     = rk_out_q;

endmodule
